// File: rtl/nand_cpu_bp_pkg.sv
// rtl/nand_cpu_bp_pkg.sv - branch predictor types and saturating counter helpers
// Contents: bp_ctr_t (2-bit taken counter), bp_entry_t (table entry),
//           bp_ctr_inc/bp_ctr_dec (saturating), bp_entry_reset (reset entry value).
// Optional feature macro: BP_TAG_CHECK_EN adds the tag field to bp_entry_t.
`include "nand_cpu.svh"

package nand_cpu_bp_pkg;

  localparam int PC_SIZE = `PC_SIZE;

  typedef enum logic [1:0] {
    BP_SNT = 2'b00,
    BP_WNT = 2'b01,
    BP_WT  = 2'b10,
    BP_ST  = 2'b11
  } bp_ctr_t;

  // The tag holds fetch_pc >> IDX_W. It is kept PC_SIZE wide so the struct does
  // not depend on the table depth; the top IDX_W bits are always zero.
  typedef struct packed {
    logic               valid;
`ifdef BP_TAG_CHECK_EN
    logic [PC_SIZE-1:0] tag;
`endif
    logic [PC_SIZE-1:0] target;
    bp_ctr_t            ctr;
  } bp_entry_t;

  function automatic bp_ctr_t bp_ctr_inc(input bp_ctr_t c);
    return (c == BP_ST) ? BP_ST : bp_ctr_t'(c + 2'b01);
  endfunction

  function automatic bp_ctr_t bp_ctr_dec(input bp_ctr_t c);
    return (c == BP_SNT) ? BP_SNT : bp_ctr_t'(c - 2'b01);
  endfunction

  function automatic bp_entry_t bp_entry_reset();
    bp_entry_t e;
    e     = '0;
    e.ctr = BP_WNT;
    return e;
  endfunction

endpackage

// File: rtl/branch_feedback_ifc.sv
// rtl/branch_feedback_ifc.sv - resolved branch/jump bundle from execute to the predictor
// Signals: branch, jump (event kind), pc (branch PC), predict_taken/predict_target
//          (what fetch predicted), feedback_taken/feedback_target (actual outcome).
// Modports: out (execute drives), in (predictor receives).
`include "nand_cpu.svh"

interface branch_feedback_ifc;
  logic                  branch;
  logic                  jump;
  logic [`PC_SIZE-1:0]   pc;
  logic                  predict_taken;
  logic [`PC_SIZE-1:0]   predict_target;
  logic                  feedback_taken;
  logic [`PC_SIZE-1:0]   feedback_target;

  modport out (
    output branch, jump, pc, predict_taken, predict_target, feedback_taken, feedback_target
  );

  modport in (
    input branch, jump, pc, predict_taken, predict_target, feedback_taken, feedback_target
  );
endinterface

// File: rtl/branch_target_table.sv
// rtl/branch_target_table.sv - direct-mapped branch target table storage
// Ports: clk, rst (async active-high, clears all entries),
//        rd_idx/rd_entry (combinational lookup read),
//        wr_idx/wr_cur (combinational read of the slot being trained),
//        wr_en/wr_entry (write of wr_idx on the rising edge).
// Optional feature macro: BP_TAG_CHECK_EN (via bp_entry_t layout).
module branch_target_table
  import nand_cpu_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bp_entry_t        rd_entry,
  input  logic [IDX_W-1:0] wr_idx,
  output bp_entry_t        wr_cur,
  input  logic             wr_en,
  input  bp_entry_t        wr_entry
);

  bp_entry_t mem [ENTRIES];

  // No bypass: a same-cycle write is only seen by reads in the next cycle.
  assign rd_entry = mem[rd_idx];
  assign wr_cur   = mem[wr_idx];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        mem[i] <= bp_entry_reset();
      end
    end else if (wr_en) begin
      mem[wr_idx] <= wr_entry;
    end
  end

endmodule

// File: rtl/nand_cpu.svh
// rtl/nand_cpu.svh - shared NAND CPU sizing macros (PC_SIZE)
`ifndef NAND_CPU_SVH
`define NAND_CPU_SVH

`define PC_SIZE 8

`endif

// File: rtl/branch_predictor.sv
// rtl/branch_predictor.sv - dynamic branch predictor with redirect and statistics
// Ports: clk, rst (async active-high); fetch_pc -> predict_taken/predict_target
//        (combinational); fb (branch_feedback_ifc.in) -> redirect/redirect_pc
//        (combinational) and table training on the clock edge;
//        branch_count/mispredict_count (saturating statistics).
// Optional feature macro: BP_TAG_CHECK_EN (tag compare on lookup and training).
module branch_predictor
  import nand_cpu_bp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PC_SIZE-1:0] fetch_pc,
  output logic               predict_taken,
  output logic [PC_SIZE-1:0] predict_target,
  branch_feedback_ifc.in     fb,
  output logic               redirect,
  output logic [PC_SIZE-1:0] redirect_pc,
  output logic [STAT_W-1:0]  branch_count,
  output logic [STAT_W-1:0]  mispredict_count
);

  localparam int IDX_W = $clog2(ENTRIES);

  bp_entry_t lk_entry;
  bp_entry_t up_entry;
  bp_entry_t wr_entry;
  logic      wr_en;
  logic      lk_hit;
  logic      up_hit;
  logic      ev;
  logic      train_taken;

  branch_target_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_btt (
    .clk      (clk),
    .rst      (rst),
    .rd_idx   (fetch_pc[IDX_W-1:0]),
    .rd_entry (lk_entry),
    .wr_idx   (fb.pc[IDX_W-1:0]),
    .wr_cur   (up_entry),
    .wr_en    (wr_en),
    .wr_entry (wr_entry)
  );

`ifdef BP_TAG_CHECK_EN
  assign lk_hit = lk_entry.valid && (lk_entry.tag == (fetch_pc >> IDX_W));
  assign up_hit = up_entry.valid && (up_entry.tag == (fb.pc >> IDX_W));
`else
  assign lk_hit = lk_entry.valid;
  assign up_hit = up_entry.valid;
`endif

  assign predict_taken  = lk_hit && lk_entry.ctr[1];
  assign predict_target = predict_taken ? lk_entry.target : fetch_pc + PC_SIZE'(1);

  // A jump is always taken, even if branch is also asserted.
  assign ev          = fb.branch | fb.jump;
  assign train_taken = fb.feedback_taken | fb.jump;

  always_comb begin
    redirect    = 1'b0;
    redirect_pc = '0;
    if (ev && ((fb.predict_taken != fb.feedback_taken) ||
               (fb.predict_taken && fb.feedback_taken &&
                (fb.predict_target != fb.feedback_target)))) begin
      redirect    = 1'b1;
      redirect_pc = fb.feedback_taken ? fb.feedback_target : fb.pc + PC_SIZE'(1);
    end
  end

  always_comb begin
    wr_en    = 1'b0;
    wr_entry = up_entry;
    if (ev) begin
      if (up_hit) begin
        wr_en = 1'b1;
        if (fb.jump) begin
          wr_entry.ctr    = BP_ST;
          wr_entry.target = fb.feedback_target;
        end else if (fb.feedback_taken) begin
          wr_entry.ctr    = bp_ctr_inc(up_entry.ctr);
          wr_entry.target = fb.feedback_target;
        end else begin
          wr_entry.ctr    = bp_ctr_dec(up_entry.ctr);
        end
      end else if (train_taken) begin
        // Miss on a taken event: overwrite the slot regardless of its owner.
        wr_en           = 1'b1;
        wr_entry.valid  = 1'b1;
`ifdef BP_TAG_CHECK_EN
        wr_entry.tag    = fb.pc >> IDX_W;
`endif
        wr_entry.target = fb.feedback_target;
        wr_entry.ctr    = fb.jump ? BP_ST : BP_WT;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      if (ev && !(&branch_count)) begin
        branch_count <= branch_count + STAT_W'(1);
      end
      if (redirect && !(&mispredict_count)) begin
        mispredict_count <= mispredict_count + STAT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb/tb_branch_predictor.sv - self-checking bench for branch_predictor
`include "nand_cpu.svh"

module tb_branch_predictor;
  import nand_cpu_bp_pkg::*;

  localparam int ENTRIES = 16;
  localparam int STAT_W  = 4;
  localparam int PCW     = PC_SIZE;
  localparam int PCMOD   = 1 << PCW;
  localparam int SMAX    = (1 << STAT_W) - 1;
`ifdef BP_TAG_CHECK_EN
  localparam bit TAGCHK = 1'b1;
`else
  localparam bit TAGCHK = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PCW-1:0]    fetch_pc;
  logic              predict_taken;
  logic [PCW-1:0]    predict_target;
  logic              redirect;
  logic [PCW-1:0]    redirect_pc;
  logic [STAT_W-1:0] bc;
  logic [STAT_W-1:0] mc;

  branch_feedback_ifc fbi ();

  branch_predictor #(.ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .fetch_pc         (fetch_pc),
    .predict_taken    (predict_taken),
    .predict_target   (predict_target),
    .fb               (fbi),
    .redirect         (redirect),
    .redirect_pc      (redirect_pc),
    .branch_count     (bc),
    .mispredict_count (mc)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: plain integer table, counter 0..3.
  bit m_valid [ENTRIES];
  int m_tag   [ENTRIES];
  int m_tgt   [ENTRIES];
  int m_ctr   [ENTRIES];
  int m_bc, m_mc;

  // Inputs currently applied.
  int c_fpc, c_br, c_jp, c_pc, c_ptk, c_ptg, c_ftk, c_ftg;

  function automatic void m_reset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endfunction

  function automatic bit m_hit(input int pc);
    int idx = pc % ENTRIES;
    return m_valid[idx] && (!TAGCHK || m_tag[idx] == pc / ENTRIES);
  endfunction

  function automatic int m_ptk(input int pc);
    return (m_hit(pc) && m_ctr[pc % ENTRIES] >= 2) ? 1 : 0;
  endfunction

  function automatic int m_ptg(input int pc);
    return m_ptk(pc) ? m_tgt[pc % ENTRIES] : (pc + 1) % PCMOD;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int fpc, input int br, input int jp, input int pc,
                       input int ptk, input int ptg, input int ftk, input int ftg);
    c_fpc = fpc; c_br = br; c_jp = jp; c_pc = pc;
    c_ptk = ptk; c_ptg = ptg; c_ftk = ftk; c_ftg = ftg;
    fetch_pc            = PCW'(fpc);
    fbi.branch          = (br != 0);
    fbi.jump            = (jp != 0);
    fbi.pc              = PCW'(pc);
    fbi.predict_taken   = (ptk != 0);
    fbi.predict_target  = PCW'(ptg);
    fbi.feedback_taken  = (ftk != 0);
    fbi.feedback_target = PCW'(ftg);
  endtask

  // Checks every output against the model on the falling edge, then applies
  // the model update the rising edge is expected to perform.
  task automatic tick();
    int ev, redir, rpc, idx, tk;
    @(negedge clk);
    ev    = (c_br != 0 || c_jp != 0) ? 1 : 0;
    redir = (ev != 0 && (c_ptk != c_ftk || (c_ptk != 0 && c_ftk != 0 && c_ptg != c_ftg))) ? 1 : 0;
    rpc   = redir != 0 ? (c_ftk != 0 ? c_ftg : (c_pc + 1) % PCMOD) : 0;
    chk("predict_taken",    32'(predict_taken),  32'(m_ptk(c_fpc)));
    chk("predict_target",   32'(predict_target), 32'(m_ptg(c_fpc)));
    chk("redirect",         32'(redirect),       32'(redir));
    chk("redirect_pc",      32'(redirect_pc),    32'(rpc));
    chk("branch_count",     32'(bc),             32'(m_bc));
    chk("mispredict_count", 32'(mc),             32'(m_mc));
    if (ev != 0) begin
      idx = c_pc % ENTRIES;
      tk  = (c_ftk != 0 || c_jp != 0) ? 1 : 0;
      if (m_bc < SMAX) m_bc++;
      if (redir != 0 && m_mc < SMAX) m_mc++;
      if (m_hit(c_pc)) begin
        if (c_jp != 0) begin
          m_ctr[idx] = 3; m_tgt[idx] = c_ftg;
        end else if (tk != 0) begin
          m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1; m_tgt[idx] = c_ftg;
        end else begin
          m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
        end
      end else if (tk != 0) begin
        m_valid[idx] = 1'b1; m_tag[idx] = c_pc / ENTRIES; m_tgt[idx] = c_ftg;
        m_ctr[idx] = (c_jp != 0) ? 3 : 2;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Combinational lookup probe against fixed expectations; no feedback applied.
  task automatic look(input int pc, input int exp_tk, input int exp_tg, input string tag);
    drive(pc, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk({tag, "_taken"},  32'(predict_taken),  32'(exp_tk));
    chk({tag, "_target"}, 32'(predict_target), 32'(exp_tg));
  endtask

  initial begin
    int pc, fpc, br, jp, ptk, ptg, ftk;
    m_reset();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state.
    look(5, 0, 'h06, "reset_lookup");
    chk("reset_branch_count", 32'(bc), 0);
    chk("reset_mispredict_count", 32'(mc), 0);

    // Allocation on a taken miss: redirect same cycle, no bypass, visible next cycle.
    drive(5, 1, 0, 5, 0, 0, 1, 'h20);
    #1;
    chk("alloc_redirect", 32'(redirect), 1);
    chk("alloc_redirect_pc", 32'(redirect_pc), 'h20);
    chk("alloc_no_bypass", 32'(predict_taken), 0);
    tick();
    look(5, 1, 'h20, "alloc_lookup");

    // Train down to strongly not-taken, then back up.
    drive(5, 1, 0, 5, 1, 'h20, 0, 0);
    #1;
    chk("nt_redirect_pc", 32'(redirect_pc), 'h06);
    tick();
    drive(5, 1, 0, 5, 0, 0, 0, 0); tick();
    drive(5, 1, 0, 5, 0, 0, 0, 0); tick();
    look(5, 0, 'h06, "trained_down");
    drive(5, 1, 0, 5, 0, 0, 1, 'h20); tick();
    look(5, 0, 'h06, "one_taken");
    drive(5, 1, 0, 5, 0, 0, 1, 'h20); tick();
    look(5, 1, 'h20, "two_taken");

    // Jump on a miss allocates strongly taken; one not-taken leaves it taken.
    drive(9, 0, 1, 9, 0, 0, 1, 'h30); tick();
    look(9, 1, 'h30, "jump_alloc");
    drive(9, 1, 0, 9, 1, 'h30, 0, 0); tick();
    look(9, 1, 'h30, "jump_weakened");

    // Aliasing PC sharing slot 5.
    if (TAGCHK) look(5 + ENTRIES, 0, 5 + ENTRIES + 1, "alias_tagged");
    else        look(5 + ENTRIES, 1, 'h20, "alias_untagged");

    // All-ones fetch on a miss wraps to zero.
    look(PCMOD - 1, 0, 0, "wrap_target");

    // Drive the statistics counters into saturation.
    for (int i = 0; i < 12; i++) begin
      drive(0, 1, 0, 'h40 + i, 0, 0, 1, $urandom_range(0, PCMOD - 1));
      tick();
    end
    #1;
    chk("sat_mispredict_count", 32'(mc), 32'(SMAX));
    chk("sat_branch_count", 32'(bc), 32'(SMAX));

    // Randomized traffic with aliasing PCs and mixed predictions.
    for (int i = 0; i < 300; i++) begin
      pc  = ($urandom_range(0, 9) == 0) ? PCMOD - 1
                                        : $urandom_range(0, 7) + ENTRIES * $urandom_range(0, 1);
      fpc = ($urandom_range(0, 3) == 0) ? $urandom_range(0, PCMOD - 1) : pc;
      br  = ($urandom_range(0, 9) < 7) ? 1 : 0;
      jp  = ($urandom_range(0, 6) == 0) ? 1 : 0;
      ftk = (jp != 0) ? 1 : $urandom_range(0, 1);
      if ($urandom_range(0, 1) == 1) begin
        ptk = m_ptk(pc); ptg = m_ptg(pc);
      end else begin
        ptk = $urandom_range(0, 1); ptg = $urandom_range(0, PCMOD - 1);
      end
      drive(fpc, br, jp, pc, ptk, ptg, ftk, $urandom_range(0, PCMOD - 1));
      tick();
    end

    // Asynchronous reset in the middle of a training cycle.
    drive(5, 1, 0, 5, 0, 0, 1, 'h20); tick();
    drive(5, 1, 0, 5, 0, 0, 1, 'h20); tick();
    look(5, 1, 'h20, "pre_reset");
    drive(5, 1, 0, 5, 0, 0, 1, 'h24);
    #1 rst = 1'b1;
    #1;
    chk("mid_reset_taken", 32'(predict_taken), 0);
    chk("mid_reset_target", 32'(predict_target), 'h06);
    chk("mid_reset_branch_count", 32'(bc), 0);
    chk("mid_reset_mispredict_count", 32'(mc), 0);
    m_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(5, 0, 0, 0, 0, 0, 0, 0);
    tick();
    look(5, 0, 'h06, "post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
